// File: rtl/demux7_dispatcher_pkg.sv
// Shared constants, state encoding and helpers for the 7-way demux dispatcher.
// Contents:
//   Width/Nch/SelW         - datapath word width, channel count, select width
//   StallMax/StallCntW     - stall threshold and its counter width
//   IllegalDest/LastCh     - unused select code and the highest legal channel
//   state_e                - dispatcher FSM states
//   onehot()               - select code to per-channel valid vector
package demux7_dispatcher_pkg;

    localparam int unsigned Width     = 13;
    localparam int unsigned Nch       = 7;
    localparam int unsigned SelW      = 3;
    localparam int unsigned StallMax  = 15;
    localparam int unsigned StallCntW = 4;

    localparam logic [SelW-1:0] IllegalDest = 3'd7;
    localparam logic [SelW-1:0] LastCh      = 3'd6;

    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } state_e;

    function automatic logic [Nch-1:0] onehot(input logic [SelW-1:0] s);
        logic [Nch-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux7_dispatcher_if.sv
// Handshake bundle between the producer, the dispatcher and the demux consumers.
// Signals:
//   in_valid/in_ready/in_data/in_dest/mode - producer side word handshake
//   sel/out_data                           - demux select and data
//   out_valid/out_ready                    - per-consumer handshake
//   drop_err/stall                         - status
// Modports: slave = dispatcher view, master = producer/consumer view.
interface demux7_dispatcher_if;
    import demux7_dispatcher_pkg::*;

    logic             in_valid;
    logic [Width-1:0] in_data;
    logic [SelW-1:0]  in_dest;
    logic             mode;
    logic             in_ready;
    logic [SelW-1:0]  sel;
    logic [Width-1:0] out_data;
    logic [Nch-1:0]   out_valid;
    logic [Nch-1:0]   out_ready;
    logic             drop_err;
    logic             stall;

    modport slave (
        input  in_valid, in_data, in_dest, mode, out_ready,
        output in_ready, sel, out_data, out_valid, drop_err, stall
    );

    modport master (
        output in_valid, in_data, in_dest, mode, out_ready,
        input  in_ready, sel, out_data, out_valid, drop_err, stall
    );

endinterface

// File: rtl/demux7_dispatcher_rr_pointer.sv
// Round-robin channel pointer: mod-Nch wrap counter with advance enable.
// Ports:
//   clk_i       - clock
//   rst_ni      - synchronous active-low reset (pointer -> 0)
//   advance_i   - step to the next channel this cycle
//   ptr_o       - current pointer
//   ptr_next_o  - value the pointer takes at the next edge
module demux7_dispatcher_rr_pointer
    import demux7_dispatcher_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            advance_i,
    output logic [SelW-1:0] ptr_o,
    output logic [SelW-1:0] ptr_next_o
);

    logic [SelW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (ptr_q == LastCh) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o      = ptr_q;
    assign ptr_next_o = ptr_d;

endmodule

// File: rtl/demux7_dispatcher.sv
// Dispatcher sequencing the external 7-way demux: takes one word at a time from
// the producer, holds it in the output register and presents it to the chosen
// consumer until that consumer is ready. Round-robin or directed routing.
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - synchronous active-low reset; discards any held word
//   dsp_io  - handshake bundle (slave modport), see demux7_dispatcher_if
module demux7_dispatcher
    import demux7_dispatcher_pkg::*;
(
    input logic                clk_i,
    input logic                rst_ni,
    demux7_dispatcher_if.slave dsp_io
);

    state_e               state_q, state_d;
    logic [SelW-1:0]      sel_q, sel_d;
    logic [Width-1:0]     data_q, data_d;
    logic                 rr_word_q, rr_word_d;  // held word was routed round-robin
    logic                 drop_q, drop_d;
    logic [StallCntW-1:0] stall_cnt_q, stall_cnt_d;

    logic            hold, transfer, accept, drop, load;
    logic [SelW-1:0] rr_ptr, rr_next, channel;

    // A mode-0 word accepted in the same cycle as a round-robin transfer must
    // take the post-advance pointer, otherwise full-rate streams repeat a channel.
    demux7_dispatcher_rr_pointer u_rr_pointer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .advance_i  (transfer & rr_word_q),
        .ptr_o      (rr_ptr),
        .ptr_next_o (rr_next)
    );

    always_comb begin
        hold     = (state_q == StHold);
        transfer = hold & dsp_io.out_ready[sel_q];
        accept   = dsp_io.in_valid & (~hold | dsp_io.out_ready[sel_q]);
        drop     = accept & dsp_io.mode & (dsp_io.in_dest > LastCh);
        load     = accept & ~drop;
        channel  = dsp_io.mode ? dsp_io.in_dest : rr_next;

        state_d     = state_q;
        sel_d       = sel_q;
        data_d      = data_q;
        rr_word_d   = rr_word_q;
        drop_d      = drop;
        stall_cnt_d = stall_cnt_q;

        if (load) begin
            state_d   = StHold;
            sel_d     = channel;
            data_d    = dsp_io.in_data;
            rr_word_d = ~dsp_io.mode;
        end else if (transfer || drop) begin
            state_d = StIdle;
        end

        if (load || transfer) begin
            stall_cnt_d = '0;
        end else if (hold && (stall_cnt_q != StallCntW'(StallMax))) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            data_q      <= '0;
            rr_word_q   <= 1'b0;
            drop_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            rr_word_q   <= rr_word_d;
            drop_q      <= drop_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign dsp_io.in_ready  = ~hold | dsp_io.out_ready[sel_q];
    assign dsp_io.sel       = sel_q;
    assign dsp_io.out_data  = data_q;
    assign dsp_io.out_valid = hold ? onehot(sel_q) : '0;
    assign dsp_io.drop_err  = drop_q;
    assign dsp_io.stall     = hold & (stall_cnt_q == StallCntW'(StallMax));

endmodule

// File: tb/tb_demux7_dispatcher.sv
module tb_demux7_dispatcher;
    import demux7_dispatcher_pkg::*;

    typedef struct {
        logic [2:0]  ch;
        logic [12:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [2:0] rr_m;

    demux7_dispatcher_if dif ();

    demux7_dispatcher u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .dsp_io (dif)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] rr_nxt(input logic [2:0] p);
        return (p == 3'd6) ? 3'd0 : p + 3'd1;
    endfunction

    function automatic logic [6:0] oh(input logic [2:0] c);
        logic [6:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // Drive one cycle of inputs just after the falling edge.
    task automatic drive(input logic v, input logic [12:0] d, input logic [2:0] dest,
                         input logic m, input logic [6:0] rdy);
        @(negedge clk);
        dif.in_valid  = v;
        dif.in_data   = d;
        dif.in_dest   = dest;
        dif.mode      = m;
        dif.out_ready = rdy;
        #1;
    endtask

    // Scoreboard: every completed consumer transfer pops the oldest expected word.
    always @(negedge clk) begin
        #2;
        if (rst_n === 1'b1 && (dif.out_valid & dif.out_ready) != 7'd0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got sel=%0d data=%h, expected no transfer",
                         dif.sel, dif.out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++;
                if (dif.sel !== e.ch || dif.out_data !== e.data || dif.out_valid !== oh(e.ch)) begin
                    n_err++;
                    $display("FAIL sb_word: got sel=%0d data=%h valid=%b, expected sel=%0d data=%h valid=%b",
                             dif.sel, dif.out_data, dif.out_valid, e.ch, e.data, oh(e.ch));
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 13'h0AAA, 3'd2, 1'b0, 7'h00);
        drive(1'b1, 13'h0AAA, 3'd2, 1'b0, 7'h00);
        n_cmp++; if (dif.in_ready !== 1'b1) begin n_err++;
            $display("FAIL rst_in_ready: got %b expected 1", dif.in_ready); end
        n_cmp++; if (dif.out_valid !== 7'd0) begin n_err++;
            $display("FAIL rst_out_valid: got %b expected 0", dif.out_valid); end
        n_cmp++; if (dif.sel !== 3'd0) begin n_err++;
            $display("FAIL rst_sel: got %0d expected 0", dif.sel); end
        n_cmp++; if (dif.out_data !== 13'd0) begin n_err++;
            $display("FAIL rst_out_data: got %h expected 0", dif.out_data); end
        n_cmp++; if (dif.drop_err !== 1'b0) begin n_err++;
            $display("FAIL rst_drop_err: got %b expected 0", dif.drop_err); end
        n_cmp++; if (dif.stall !== 1'b0) begin n_err++;
            $display("FAIL rst_stall: got %b expected 0", dif.stall); end
        drive(1'b0, 13'h0, 3'd0, 1'b0, 7'h7F);
        rst_n = 1'b1;
        rr_m  = 3'd0;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 13'h1555, 3'd0, 1'b0, 7'h7F);
            n_cmp++; if (dif.in_ready !== 1'b1) begin n_err++;
                $display("FAIL rr_in_ready[%0d]: got %b expected 1", i, dif.in_ready); end
            if (i > 0) begin
                n_cmp++; if (dif.out_valid === 7'd0) begin n_err++;
                    $display("FAIL rr_full_rate[%0d]: got out_valid=%b expected nonzero",
                             i, dif.out_valid); end
            end
            sb.push_back('{ch: rr_m, data: 13'h1555});
            rr_m = rr_nxt(rr_m);
        end
        drive(1'b0, 13'h0, 3'd0, 1'b0, 7'h7F);
        drive(1'b0, 13'h0, 3'd0, 1'b0, 7'h7F);
        n_cmp++; if (dif.out_valid !== 7'd0) begin n_err++;
            $display("FAIL rr_idle: got %b expected 0", dif.out_valid); end
        n_cmp++; if (sb.size() != 0) begin n_err++;
            $display("FAIL rr_drained: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_directed_backpressure();
        drive(1'b1, 13'h0ABC, 3'd3, 1'b1, 7'h77);
        sb.push_back('{ch: 3'd3, data: 13'h0ABC});
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 13'h0, 3'd0, 1'b0, 7'h77);
            n_cmp++; if (dif.out_valid !== 7'b0001000) begin n_err++;
                $display("FAIL bp_valid[%0d]: got %b expected 0001000", i, dif.out_valid); end
            n_cmp++; if (dif.in_ready !== 1'b0) begin n_err++;
                $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, dif.in_ready); end
        end
        drive(1'b0, 13'h0, 3'd0, 1'b0, 7'h7F);
        n_cmp++; if (dif.out_valid !== 7'b0001000 || dif.in_ready !== 1'b1) begin n_err++;
            $display("FAIL bp_release: got valid=%b ready=%b expected 0001000/1",
                     dif.out_valid, dif.in_ready); end
        // Round-robin pointer must be untouched by the directed word.
        drive(1'b1, 13'h1234, 3'd0, 1'b0, 7'h7F);
        sb.push_back('{ch: rr_m, data: 13'h1234});
        rr_m = rr_nxt(rr_m);
        // Last legal directed channel, back-to-back with the round-robin word.
        drive(1'b1, 13'h1F0F, 3'd6, 1'b1, 7'h7F);
        sb.push_back('{ch: 3'd6, data: 13'h1F0F});
        drive(1'b0, 13'h0, 3'd0, 1'b0, 7'h7F);
        drive(1'b0, 13'h0, 3'd0, 1'b0, 7'h7F);
        n_cmp++; if (sb.size() != 0) begin n_err++;
            $display("FAIL bp_drained: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_illegal_dest();
        drive(1'b1, 13'h0777, IllegalDest, 1'b1, 7'h7F);
        drive(1'b0, 13'h0, 3'd0, 1'b0, 7'h7F);
        n_cmp++; if (dif.drop_err !== 1'b1) begin n_err++;
            $display("FAIL drop_pulse: got %b expected 1", dif.drop_err); end
        n_cmp++; if (dif.out_valid !== 7'd0 || dif.in_ready !== 1'b1) begin n_err++;
            $display("FAIL drop_idle: got valid=%b ready=%b expected 0/1",
                     dif.out_valid, dif.in_ready); end
        drive(1'b0, 13'h0, 3'd0, 1'b0, 7'h7F);
        n_cmp++; if (dif.drop_err !== 1'b0) begin n_err++;
            $display("FAIL drop_one_cycle: got %b expected 0", dif.drop_err); end
        drive(1'b1, 13'h0001, IllegalDest, 1'b1, 7'h7F);
        drive(1'b1, 13'h0002, IllegalDest, 1'b1, 7'h7F);
        n_cmp++; if (dif.drop_err !== 1'b1) begin n_err++;
            $display("FAIL drop_b2b_first: got %b expected 1", dif.drop_err); end
        drive(1'b0, 13'h0, 3'd0, 1'b0, 7'h7F);
        n_cmp++; if (dif.drop_err !== 1'b1 || dif.out_valid !== 7'd0) begin n_err++;
            $display("FAIL drop_b2b_second: got drop=%b valid=%b expected 1/0",
                     dif.drop_err, dif.out_valid); end
        drive(1'b0, 13'h0, 3'd0, 1'b0, 7'h7F);
        n_cmp++; if (dif.drop_err !== 1'b0) begin n_err++;
            $display("FAIL drop_b2b_end: got %b expected 0", dif.drop_err); end
    endtask

    task automatic test_stall();
        drive(1'b1, 13'h1ACE, 3'd0, 1'b0, 7'h00);
        sb.push_back('{ch: rr_m, data: 13'h1ACE});
        rr_m = rr_nxt(rr_m);
        for (int j = 1; j <= 20; j++) begin
            drive(1'b0, 13'h0, 3'd0, 1'b0, 7'h00);
            n_cmp++; if (dif.stall !== (j >= 16)) begin n_err++;
                $display("FAIL stall_cycle[%0d]: got %b expected %b", j, dif.stall, (j >= 16)); end
        end
        drive(1'b0, 13'h0, 3'd0, 1'b0, 7'h7F);
        n_cmp++; if (dif.stall !== 1'b1) begin n_err++;
            $display("FAIL stall_at_transfer: got %b expected 1", dif.stall); end
        drive(1'b0, 13'h0, 3'd0, 1'b0, 7'h7F);
        n_cmp++; if (dif.stall !== 1'b0 || dif.out_valid !== 7'd0) begin n_err++;
            $display("FAIL stall_clear: got stall=%b valid=%b expected 0/0",
                     dif.stall, dif.out_valid); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 13'h0BAD, 3'd4, 1'b1, 7'h00);
        drive(1'b0, 13'h0, 3'd0, 1'b0, 7'h00);
        n_cmp++; if (dif.out_valid !== 7'b0010000) begin n_err++;
            $display("FAIL mid_hold: got %b expected 0010000", dif.out_valid); end
        rst_n = 1'b0;
        drive(1'b0, 13'h0, 3'd0, 1'b0, 7'h00);
        rst_n = 1'b1;
        rr_m  = 3'd0;
        drive(1'b0, 13'h0, 3'd0, 1'b0, 7'h7F);
        n_cmp++; if (dif.out_valid !== 7'd0 || dif.sel !== 3'd0) begin n_err++;
            $display("FAIL mid_reset: got valid=%b sel=%0d expected 0/0",
                     dif.out_valid, dif.sel); end
        // Pointer was 3 before reset; the next round-robin word must go to 0.
        drive(1'b1, 13'h0C0C, 3'd0, 1'b0, 7'h7F);
        sb.push_back('{ch: rr_m, data: 13'h0C0C});
        rr_m = rr_nxt(rr_m);
        drive(1'b0, 13'h0, 3'd0, 1'b0, 7'h7F);
        drive(1'b0, 13'h0, 3'd0, 1'b0, 7'h7F);
        n_cmp++; if (sb.size() != 0) begin n_err++;
            $display("FAIL mid_drained: got %0d pending expected 0", sb.size()); end
    endtask

    initial begin
        rst_n         = 1'b0;
        rr_m          = 3'd0;
        dif.in_valid  = 1'b0;
        dif.in_data   = '0;
        dif.in_dest   = '0;
        dif.mode      = 1'b0;
        dif.out_ready = '0;
        test_reset();
        test_round_robin();
        test_directed_backpressure();
        test_illegal_dest();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux7_dispatcher.md
Name: demux7_dispatcher

Overview:
Controller that sequences the 7-way, 13-bit demux datapath. Accepts words from one producer over a valid/ready handshake and holds each word in an output register. Drives the demux select and data together with a per-channel valid, and waits for the addressed consumer's ready before taking the next word. Supports round-robin and directed routing, reports bad destinations, and flags stalled consumers.

Parameters:
WIDTH, 13, data word width (demux in/out width)
NCH, 7, number of output channels
SELW, 3, select width; channel codes 0..NCH-1 are legal, code 7 is illegal
STALL_MAX, 15, cycles a held word may wait before stall is raised

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  producer has a word
in_data  input  WIDTH  producer word
in_dest  input  SELW  destination channel (directed mode)
mode  input  1  0 = round-robin, 1 = directed; sampled at capture
in_ready  output  1  dispatcher can accept a word this cycle
sel  output  SELW  demux select
out_data  output  WIDTH  word driven into demux input
out_valid  output  NCH  one-hot valid; bit sel set while a word is held
out_ready  input  NCH  per-consumer ready
drop_err  output  1  one-cycle pulse: directed word with dest >= NCH dropped
stall  output  1  level: held word waited STALL_MAX cycles

Behaviour:
- Reset (rst_n=0 at a posedge): state=IDLE, rr_ptr=0, sel=0, out_data=0, out_valid=0, drop_err=0, stall=0, stall_cnt=0. Any held word is discarded, including reset during HOLD.
- States:
  - IDLE: no word held.
  - HOLD: word held in the output register.
- in_ready (combinational) = (state==IDLE) | (state==HOLD & out_ready[sel]).
- Accept = in_valid & in_ready.
- Route on accept:
  - mode=0: channel = rr_ptr.
  - mode=1: channel = in_dest.
  - If mode=1 and in_dest >= NCH: word dropped, drop_err=1 next cycle, no out_valid. State goes to IDLE, or stays IDLE if already IDLE.
  - Otherwise, at the accepting edge: sel<=channel, out_data<=in_data, state<=HOLD. Latency is one cycle: out_valid[channel] is visible the cycle after the accept.
- In HOLD:
  - out_valid = one-hot(sel); all other bits are 0.
  - sel and out_data are stable until transfer.
- Transfer = HOLD & out_ready[sel]. out_ready bits for other channels are ignored.
- On transfer, with no simultaneous accept: state<=IDLE.
- Transfer and accept in the same cycle: the new word loads and state stays HOLD, giving one word per cycle at full throughput.
- rr_ptr advances only on a transfer of a word captured in mode 0: rr_ptr <= (sel==NCH-1) ? 0 : sel+1 (wrap 6->0). Directed words never move rr_ptr.
- Round-robin is strict; a not-ready channel is never skipped.
- IDLE: out_valid=0; sel and out_data keep their last values.
- stall_cnt:
  - Cleared on entering HOLD or on transfer.
  - Otherwise increments each HOLD cycle, saturating at STALL_MAX.
  - stall = (stall_cnt==STALL_MAX) & HOLD; it clears in the cycle after transfer.
- drop_err is registered and lasts exactly one cycle per dropped word. Back-to-back drops give back-to-back pulses.

Decomposition:
- Shared package/include: state encodings IDLE=1'b0, HOLD=1'b1; NCH, SELW, WIDTH defaults; ILLEGAL_DEST=3'd7.
- One natural sub-module, rr_pointer: the mod-NCH wrap counter with advance enable and synchronous active-low reset.
- The demux itself stays external and connects via sel/out_data.

Test Plan:
- Reset values: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=7'b0, sel=0, drop_err=0, stall=0.
- Round-robin full rate: mode=0, out_ready=7'h7F, 8 words 13'h1555 back-to-back -> sel 0,1,2,3,4,5,6,0 on consecutive cycles, out_data=13'h1555, in_ready stays 1.
- Directed backpressure: mode=1, in_dest=3, out_ready[3]=0 for 4 cycles -> out_valid=7'b0001000 held 5 cycles, in_ready=0 for the 4 blocked cycles; transfer on cycle 5; rr_ptr unchanged.
- Illegal destination: mode=1, in_dest=7 -> drop_err pulses exactly 1 cycle, out_valid stays 0, state stays IDLE.
- Stall: mode=0, out_ready=0 for 20 cycles -> stall rises after 15 HOLD cycles and stays high; raising out_ready[0] clears it the cycle after transfer.
- Reset mid-operation: rst_n=0 during HOLD on sel=4 -> next cycle out_valid=0, sel=0, rr_ptr=0; the word never reaches a consumer.
